id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 64, operand/immediate width.
REQ-002 Parameter: CTRL_W, 16, control bundle width; bit0 RegWrite, bit1 MemRead, bit2 MemWrite, remaining bits opaque.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 id_valid  input  1  decode slot holds a real instruction.
REQ-006 id_rd1, id_rd2  input  DATA_W  register-file read ports 1/2 for current decode instruction.
REQ-007 id_rn, id_rm, id_rd  input  5  source 1, source 2, destination register numbers.
REQ-008 id_uses_rn, id_uses_rm  input  1  instruction actually reads rn / rm.
REQ-009 id_imm  input  DATA_W  sign-extended immediate.
REQ-010 id_ctrl  input  CTRL_W  decoded control bundle.
REQ-011 wb_regwrite  input  1; wb_rd  input  5; wb_data  input  DATA_W  write-back port driving register-file write this cycle.
REQ-012 flush  input  1  squash decode slot (taken branch).
REQ-013 stall  output  1  hold PC and IF/ID register this cycle.
REQ-014 ex_valid  output  1; ex_a, ex_b  output  DATA_W; ex_rn, ex_rm, ex_rd  output  5; ex_imm  output  DATA_W; ex_ctrl  output  CTRL_W  registered execute-stage bundle.
REQ-015 stall_count  output  32  saturating count of stall cycles since reset.

Function
REQ-016 load_use = ex_valid & ex_ctrl[1] & (ex_rd != 31) & id_valid & ((id_uses_rn & id_rn == ex_rd) | (id_uses_rm & id_rm == ex_rd)).
REQ-017 stall SHALL equal load_use & ~flush, combinational, same cycle.
REQ-018 Bypass A: ex_a captures wb_data when wb_regwrite & wb_rd != 31 & wb_rd == id_rn, else id_rd1.
REQ-019 Bypass B: ex_b captures wb_data when wb_regwrite & wb_rd != 31 & wb_rd == id_rm, else id_rd2.
REQ-020 Register 31 SHALL never be bypassed; a source of 31 always captures the port value (zero).
REQ-021 Edge priority: flush > stall > normal capture.
REQ-022 flush or stall edge: insert bubble -- ex_valid=0, ex_ctrl=0, ex_a/ex_b/ex_imm=0, ex_rn/ex_rm/ex_rd=31.
REQ-023 Normal edge: ex_valid<=id_valid; ex_ctrl<=id_valid ? id_ctrl : 0; all other fields captured from id_* / bypass result.
REQ-024 id_valid=0 on normal edge SHALL produce a bubble identical to REQ-022 except fields may capture inputs; ex_ctrl forced 0.
REQ-025 Latency: one cycle from decode inputs to ex_* outputs; no combinational path from id_* to ex_*.
REQ-026 stall_count increments by 1 on each edge where stall=1; holds at 0xFFFFFFFF.
REQ-027 Consecutive stalls: each stalled edge re-evaluates load_use against the new ex_* (a bubble), so a single load produces exactly one stall cycle.
REQ-028 flush and load_use simultaneous: stall=0, bubble inserted, stall_count unchanged.

Reset
REQ-029 reset=1 SHALL immediately (no clock) force ex_valid=0, ex_ctrl=0, ex_a/ex_b/ex_imm=0, ex_rn/ex_rm/ex_rd=31, stall_count=0.
REQ-030 stall SHALL read 0 while reset is asserted (follows from ex_valid=0).
REQ-031 Reset asserted mid-stall SHALL discard pending bubble; first edge after deassert performs normal capture.

Verification
REQ-032 Plain capture: id_valid=1, id_rn=1, id_rm=2, id_rd1=0x11, id_rd2=0x22, id_ctrl=0x0001, no WB -> next cycle ex_a=0x11, ex_b=0x22, ex_ctrl=0x0001, ex_valid=1.
REQ-033 WB bypass: wb_regwrite=1, wb_rd=3, wb_data=0xDEAD, id_rn=3, id_rm=3, id_rd1=id_rd2=0x5 -> ex_a=ex_b=0xDEAD; repeat with wb_rd=31, id_rn=31, id_rd1=0 -> ex_a=0.
REQ-034 Load-use: ex holds load (ctrl bit1=1, ex_rd=4), id_rn=4 uses_rn=1 -> stall=1 one cycle, ex_valid=0 next, stall_count=1; following cycle stall=0, instruction captured.
REQ-035 Flush vs stall: load-use condition plus flush=1 -> stall=0, bubble inserted, stall_count unchanged.
REQ-036 Async reset: assert reset between edges with ex_valid=1 -> outputs reach reset values before next edge; stall_count=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register with load-use hazard detection and a write-back
// bypass into the captured operands.
//
// Every decode slot either moves into the execute registers on the next rising
// edge or becomes a bubble. A bubble has ex_valid = 0, ex_ctrl = 0, zeroed data
// fields and register numbers of 31.
//
// Ports
//   clk, reset        single clock; asynchronous active-high reset
//   id_valid          decode slot holds a real instruction
//   id_rd1, id_rd2    register-file read data for rn / rm
//   id_rn/rm/rd       source 1, source 2 and destination register numbers
//   id_uses_rn/rm     instruction really reads rn / rm
//   id_imm            sign-extended immediate
//   id_ctrl           control bundle (bit0 RegWrite, bit1 MemRead, bit2 MemWrite)
//   wb_regwrite/rd/data  write-back port, written to the register file this cycle
//   flush             squash the decode slot (taken branch)
//   stall             hold PC and IF/ID this cycle (load-use hazard)
//   ex_*              registered execute-stage bundle
//   stall_count       saturating count of stalled edges since reset
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [4:0]        id_rn,
    input  logic [4:0]        id_rm,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rn,
    input  logic              id_uses_rm,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,

    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,

    input  logic              flush,
    output logic              stall,

    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [4:0]        ex_rn,
    output logic [4:0]        ex_rm,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,

    output logic [31:0]       stall_count
);

    // Register 31 reads as zero and is never a real forwarding target.
    localparam logic [4:0]  ZeroReg    = 5'd31;
    localparam int unsigned MemReadBit = 1;

    logic              exIsLoad;
    logic              rnHazard;
    logic              rmHazard;
    logic              loadUse;
    logic              bubble;
    logic              bypassA;
    logic              bypassB;
    logic [DATA_W-1:0] operandA;
    logic [DATA_W-1:0] operandB;
    logic              countSaturated;

    // ------------------------------------------------------------------
    // Load-use hazard: the instruction in EX is a load whose result is
    // not available yet, and decode reads that destination.
    // ------------------------------------------------------------------
    always_comb begin
        exIsLoad = ex_valid & ex_ctrl[MemReadBit] & (ex_rd != ZeroReg);
        rnHazard = id_uses_rn & (id_rn == ex_rd);
        rmHazard = id_uses_rm & (id_rm == ex_rd);
        loadUse  = exIsLoad & id_valid & (rnHazard | rmHazard);
    end

    // A flush throws the decode slot away anyway, so holding IF/ID for it
    // would only waste a cycle. Flush therefore wins over stall.
    assign stall  = loadUse & ~flush;
    assign bubble = flush | stall;

    // ------------------------------------------------------------------
    // Write-back bypass. The register file is written at the same edge
    // that this stage captures, so the read ports still show the old
    // value. Register 31 is excluded so a zero source stays zero.
    // ------------------------------------------------------------------
    always_comb begin
        bypassA  = wb_regwrite & (wb_rd != ZeroReg) & (wb_rd == id_rn);
        bypassB  = wb_regwrite & (wb_rd != ZeroReg) & (wb_rd == id_rm);
        operandA = bypassA ? wb_data : id_rd1;
        operandB = bypassB ? wb_data : id_rd2;
    end

    // ------------------------------------------------------------------
    // Execute-stage bundle. Priority: reset > flush/stall bubble > capture.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rn    <= ZeroReg;
            ex_rm    <= ZeroReg;
            ex_rd    <= ZeroReg;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else if (bubble) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rn    <= ZeroReg;
            ex_rm    <= ZeroReg;
            ex_rd    <= ZeroReg;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_a     <= operandA;
            ex_b     <= operandB;
            ex_rn    <= id_rn;
            ex_rm    <= id_rm;
            ex_rd    <= id_rd;
            ex_imm   <= id_imm;
            // An empty decode slot must not carry side-effecting controls.
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

    // ------------------------------------------------------------------
    // Stall cycle counter, saturating at all-ones.
    // ------------------------------------------------------------------
    assign countSaturated = (stall_count == 32'hFFFF_FFFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && !countSaturated) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule
